// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/OUT sequencer that fetches one word at a time,
// holds it for decode, and steps the PC sequentially or to a resolved branch target.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] instr_o,
  output logic [5:0]  op_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic        branch_i,
  input  logic        is_bne_i,
  input  logic        zero_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] instr_count_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        run_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        taken;

  // run_q releases the FSM one edge after rst_i falls, so the release edge itself
  // never changes an output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  assign taken = branch_i & (zero_i ^ is_bne_i);

  // Handshake: instr_o is transferred on a cycle where valid_o & ready_i; valid_o
  // holds and instr_o/pc_o stay stable until then. mem_req_o holds until mem_ack_i.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    count_d   = count_q;
    mem_req_o = 1'b0;
    valid_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_q) state_d = S_REQ;
      end
      S_REQ: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          instr_d = mem_data_i;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        valid_o = 1'b1;
        if (ready_i) begin
          pc_d    = taken ? (branch_target_i & 32'hFFFF_FFFC) : (pc_q + 32'd4);
          count_d = count_q + 32'd1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr_o    = pc_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + 32'd4;
  assign instr_o       = instr_q;
  assign op_o          = instr_q[31:26];
  assign instr_count_o = count_q;
  assign dbg_state_o   = state_q;

endmodule
